// File: rtl/display_scan_mux.sv
// display_scan_mux
// Time-multiplexed channel scanner for shared display lines. Rotates an
// active-low one-hot select over CHANNELS inputs, one slot every PRESCALE
// clocks. Channels disabled in en_mask are skipped. The first BLANK_CYCLES
// of every slot are blanked to avoid ghosting. The selected channel's data
// is registered onto data_out.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   en_mask     per-channel enable (bit i = 1: channel i is scanned)
//   data_in     flattened channel data, channel i at [i*DATA_W +: DATA_W]
//   sel_n       registered active-low one-hot channel select
//   data_out    registered data of the selected channel (BLANK_VALUE when blank)
//   cur_idx     index of the channel that owns the current slot
//   frame_start one-cycle pulse when the scan wraps to a new frame
module display_scan_mux #(
    parameter int          CHANNELS     = 8,
    parameter int          DATA_W       = 8,
    parameter int          PRESCALE     = 50000,
    parameter int          BLANK_CYCLES = 500,
    parameter logic [DATA_W-1:0] BLANK_VALUE = '1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          en_mask,
    input  logic [CHANNELS*DATA_W-1:0]   data_in,
    output logic [CHANNELS-1:0]          sel_n,
    output logic [DATA_W-1:0]            data_out,
    output logic [$clog2(CHANNELS)-1:0]  cur_idx,
    output logic                         frame_start
);

    localparam int          IDX_W = $clog2(CHANNELS);
    localparam int          PW    = ($clog2(PRESCALE) < 1) ? 1 : $clog2(PRESCALE);
    localparam int unsigned CH_U  = CHANNELS;

    logic [PW-1:0]       presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CHANNELS-1:0] sel_n_q, sel_n_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                frame_start_q, frame_start_d;

    logic                tick;
    logic                any_en;
    logic                found;
    logic                blank;
    logic [IDX_W-1:0]    next_idx;
    logic [IDX_W-1:0]    cand_idx;
    int unsigned         cand;

    always_comb begin
        tick     = (presc_q == PW'(PRESCALE - 1));
        any_en   = |en_mask;
        found    = 1'b0;
        next_idx = idx_q;
        cand     = 0;
        cand_idx = '0;

        // Circular search starting at idx_q+1; the last position checked is
        // idx_q itself, so a lone enabled channel is reselected.
        for (int unsigned off = 1; off <= CH_U; off++) begin
            cand     = (32'(idx_q) + off) % CH_U;
            cand_idx = IDX_W'(cand);
            if (!found && en_mask[cand_idx]) begin
                found    = 1'b1;
                next_idx = cand_idx;
            end
        end

        presc_d       = tick ? '0 : presc_q + 1'b1;
        idx_d         = (tick && any_en) ? next_idx : idx_q;
        frame_start_d = tick && any_en && (next_idx <= idx_q);

        // Outputs are registered from next-state values so they line up
        // with the presc/idx registers in the same cycle.
        blank = (int'(presc_d) < BLANK_CYCLES) || !en_mask[idx_d] || !any_en;

        sel_n_d    = '1;
        data_out_d = BLANK_VALUE;
        if (!blank) begin
            sel_n_d[idx_d] = 1'b0;
            data_out_d     = data_in[int'(idx_d)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            sel_n_q       <= '1;
            data_out_q    <= BLANK_VALUE;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            sel_n_q       <= sel_n_d;
            data_out_q    <= data_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sel_n       = sel_n_q;
    assign data_out    = data_out_q;
    assign cur_idx     = idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Testbench for display_scan_mux: directed scenarios plus randomized
// mask/data/reset traffic, checked every cycle against a slot-level model.
module tb_display_scan_mux;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int PS = 8;
    localparam int BC = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [CH-1:0]     en_mask;
    logic [CH*DW-1:0]  data_in;
    logic [CH-1:0]     sel_n;
    logic [DW-1:0]     data_out;
    logic [1:0]        cur_idx;
    logic              frame_start;

    int checks   = 0;
    int failures = 0;

    // Model state: position inside the slot, slot owner, frame pulse.
    int m_presc = 0;
    int m_idx   = 0;
    bit m_frame = 1'b0;

    display_scan_mux #(
        .CHANNELS(CH), .DATA_W(DW), .PRESCALE(PS),
        .BLANK_CYCLES(BC), .BLANK_VALUE(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .en_mask(en_mask), .data_in(data_in),
        .sel_n(sel_n), .data_out(data_out), .cur_idx(cur_idx),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Next enabled channel after idx in ascending circular order.
    function automatic int next_enabled(input int idx, input logic [CH-1:0] mask);
        for (int k = 1; k <= CH; k++) begin
            if (mask[(idx + k) % CH]) return (idx + k) % CH;
        end
        return idx;
    endfunction

    task automatic step();
        logic [CH-1:0] exp_sel;
        logic [DW-1:0] exp_data;
        int            old;
        bit            blanked;
        @(posedge clk);
        if (reset) begin
            m_presc = 0; m_idx = 0; m_frame = 1'b0;
        end else if (m_presc == PS - 1) begin
            m_presc = 0;
            m_frame = 1'b0;
            if (en_mask != 0) begin
                old     = m_idx;
                m_idx   = next_enabled(m_idx, en_mask);
                m_frame = (m_idx <= old);
            end
        end else begin
            m_presc++;
            m_frame = 1'b0;
        end
        blanked  = (m_presc < BC) || !en_mask[m_idx] || (en_mask == 0);
        exp_sel  = blanked ? 4'b1111 : ~(4'b0001 << m_idx);
        exp_data = blanked ? 8'hFF : data_in[m_idx*DW +: DW];
        #1;
        check_eq("sel_n", 32'(sel_n), 32'(exp_sel));
        check_eq("data_out", 32'(data_out), 32'(exp_data));
        check_eq("cur_idx", 32'(cur_idx), 32'(m_idx));
        check_eq("frame_start", 32'(frame_start), 32'(m_frame));
        check_eq("onehot", 32'($countones(~sel_n) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int idx, input int pr, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_idx == idx && m_presc == pr) hit = 1'b1;
            else step();
        end
        check_eq(tag, 32'(m_idx == idx && m_presc == pr), 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        en_mask = 4'b1111;
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        run(3);
        check_eq("rst_sel", 32'(sel_n), 32'h0000000F);
        check_eq("rst_data", 32'(data_out), 32'h000000FF);

        // Full scan with all channels on.
        reset = 1'b0;
        step();
        check_eq("p1_blank1", 32'(sel_n), 32'h0000000F);
        step();
        check_eq("p1_act_sel", 32'(sel_n), 32'h0000000E);
        check_eq("p1_act_data", 32'(data_out), 32'h00000011);
        run(40);

        // Alternating channels 0 and 2.
        en_mask = 4'b0101;
        run(48);

        // Nothing enabled.
        en_mask = 4'b0000;
        run(24);
        check_eq("p3_sel", 32'(sel_n), 32'h0000000F);

        // Mid-slot data change and channel clear on ch1.
        en_mask = 4'b1111;
        run_until(1, 3, "p4_reach");
        data_in[1*DW +: DW] = 8'h5A;
        step();
        check_eq("p4_data", 32'(data_out), 32'h0000005A);
        en_mask[1] = 1'b0;
        step();
        check_eq("p4_blank", 32'(sel_n), 32'h0000000F);
        run_until(2, 0, "p4_adv");
        check_eq("p4_idx", 32'(cur_idx), 32'd2);

        // Single channel reselected every slot.
        en_mask = 4'b1000;
        run(40);

        // Reset in the middle of a ch2 slot.
        en_mask = 4'b1111;
        run_until(2, 4, "p6_reach");
        reset = 1'b1;
        step();
        check_eq("p6_sel", 32'(sel_n), 32'h0000000F);
        check_eq("p6_data", 32'(data_out), 32'h000000FF);
        check_eq("p6_idx", 32'(cur_idx), 32'd0);
        reset = 1'b0;
        run(20);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) en_mask = 4'($urandom);
            if ($urandom_range(3) == 0)
                data_in[$urandom_range(CH-1)*DW +: DW] = 8'($urandom);
            reset = ($urandom_range(79) == 0);
            step();
        end
        reset = 1'b0;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
